fetch_unit: RTL and testbench

Dual-issue instruction fetch stage that feeds the issue unit directly. Each request reads one aligned 64-bit instruction pair from instruction memory and places the words in a small instruction queue. Every cycle the stage presents the two oldest queued instructions and their PCs to the issue unit, which consumes the pair when it does not stall. On a taken branch or flush the stage discards queued and in-flight instructions and redirects fetch to the branch target.

---
 rtl/fetch_unit.sv | 166 ++++++++++++++++
 tb/tb_fetch_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit
// Dual-issue instruction fetch stage. Each request fetches one aligned 64-bit
// instruction pair into a small instruction queue. Every cycle the two oldest
// queued instructions are presented to the issue unit, which takes the pair
// when it is not stalling. A flush (with or without a taken branch) empties the
// queue, drops any outstanding response and redirects fetch.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   stall                      issue unit cannot accept the presented pair
//   flush, branch_taken        discard queued/in-flight work, redirect fetch
//   branch_target              redirect PC (bits [1:0] ignored)
//   imem_req/addr/ready        fetch request handshake (8-byte aligned address)
//   imem_rvalid/rdata          fetch response ([31:0] @addr, [63:32] @addr+4)
//   inst_a/b, pc_a/b, valid_a/b  oldest two queued instructions and their PCs
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [63:0] imem_rdata,
    output logic [31:0] inst_a,
    output logic [31:0] inst_b,
    output logic [31:0] pc_a,
    output logic [31:0] pc_b,
    output logic        valid_a,
    output logic        valid_b
);

    localparam int          PW  = $clog2(FQ_DEPTH);
    localparam int          CW  = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   r_fetch_pc;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          r_pending;
    logic          r_discard;
    logic          r_req_sel;   // word select of the outstanding request
    logic [31:0]   r_req_pc;    // 8-byte-aligned PC of the outstanding request

    logic [31:0]   r_q_inst [FQ_DEPTH];
    logic [31:0]   r_q_pc   [FQ_DEPTH];

    // branch_taken never arrives without flush; OR-ing keeps either one sufficient.
    logic          w_flush;
    logic          w_valid_a;
    logic          w_valid_b;
    logic [PW-1:0] w_head_b;
    logic [PW-1:0] w_tail_b;
    logic          w_req;
    logic          w_accept;
    logic          w_resp;
    logic [1:0]    w_enq_n;
    logic [1:0]    w_deq_n;
    logic [31:0]   w_wr0_inst;
    logic [31:0]   w_wr0_pc;
    logic [31:0]   w_wr1_inst;
    logic [31:0]   w_wr1_pc;
    logic [FQ_DEPTH-1:0] w_we0;
    logic [FQ_DEPTH-1:0] w_we1;

    assign w_flush   = flush || branch_taken;
    assign w_valid_a = (r_count >= CW'(1));
    assign w_valid_b = (r_count >= CW'(2));
    assign w_head_b  = r_head + PW'(1);
    assign w_tail_b  = r_tail + PW'(1);

    // Registered count gates requests so a full pair always fits on return.
    assign w_req    = !reset && !r_pending && !r_discard && !w_flush
                      && (r_count <= CW'(FQ_DEPTH - 2));
    assign w_accept = w_req && imem_ready;
    assign w_resp   = !reset && imem_rvalid && r_pending && !r_discard && !w_flush;

    // Odd-word requests keep only the high word; it becomes the first write.
    assign w_enq_n    = w_resp ? (r_req_sel ? 2'd1 : 2'd2) : 2'd0;
    assign w_deq_n    = (!stall && !w_flush) ? ({1'b0, w_valid_a} + {1'b0, w_valid_b}) : 2'd0;
    assign w_wr0_inst = r_req_sel ? imem_rdata[63:32] : imem_rdata[31:0];
    assign w_wr0_pc   = r_req_sel ? (r_req_pc + 32'd4) : r_req_pc;
    assign w_wr1_inst = imem_rdata[63:32];
    assign w_wr1_pc   = r_req_pc + 32'd4;

    genvar gi;
    generate
        for (gi = 0; gi < FQ_DEPTH; gi++) begin : g_we
            assign w_we0[gi] = (w_enq_n != 2'd0) && (r_tail == PW'(gi));
            assign w_we1[gi] = (w_enq_n == 2'd2) && (w_tail_b == PW'(gi));
        end
    endgenerate

    // Queue payload needs no reset: validity is carried entirely by r_count.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FQ_DEPTH; i++) begin
            if (w_we0[i]) begin
                r_q_inst[i] <= w_wr0_inst;
                r_q_pc[i]   <= w_wr0_pc;
            end else if (w_we1[i]) begin
                r_q_inst[i] <= w_wr1_inst;
                r_q_pc[i]   <= w_wr1_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_pending  <= 1'b0;
            r_discard  <= 1'b0;
            r_req_sel  <= 1'b0;
            r_req_pc   <= '0;
        end else if (w_flush) begin
            r_fetch_pc <= branch_target & 32'hFFFF_FFFC;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_pending  <= 1'b0;
            // A response still in flight must be swallowed when it lands; a
            // stale response landing right now already satisfies the discard.
            if (r_pending && !imem_rvalid) begin
                r_discard <= 1'b1;
            end else if (r_discard && imem_rvalid) begin
                r_discard <= 1'b0;
            end
        end else begin
            if (w_accept) begin
                r_pending  <= 1'b1;
                r_req_sel  <= r_fetch_pc[2];
                r_req_pc   <= r_fetch_pc & 32'hFFFF_FFF8;
                r_fetch_pc <= (r_fetch_pc & 32'hFFFF_FFF8) + 32'd8;
            end
            if (imem_rvalid && r_discard) begin
                r_discard <= 1'b0;
            end
            if (w_resp) begin
                r_pending <= 1'b0;
            end
            r_count <= r_count + CW'(w_enq_n) - CW'(w_deq_n);
            r_head  <= r_head + PW'(w_deq_n);
            r_tail  <= r_tail + PW'(w_enq_n);
        end
    end

    // Outputs are forced to their idle values for as long as reset is held.
    assign imem_req  = w_req;
    assign imem_addr = reset ? (RESET_PC & 32'hFFFF_FFF8) : (r_fetch_pc & 32'hFFFF_FFF8);
    assign valid_a   = !reset && w_valid_a;
    assign valid_b   = !reset && w_valid_b;
    assign inst_a    = valid_a ? r_q_inst[r_head]   : NOP;
    assign inst_b    = valid_b ? r_q_inst[w_head_b] : NOP;
    assign pc_a      = valid_a ? r_q_pc[r_head]     : 32'd0;
    assign pc_b      = valid_b ? r_q_pc[w_head_b]   : 32'd0;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [63:0] imem_rdata;
    logic [31:0] inst_a;
    logic [31:0] inst_b;
    logic [31:0] pc_a;
    logic [31:0] pc_b;
    logic        valid_a;
    logic        valid_b;

    int n_total;
    int n_bad;
    int lat;
    int m_cnt;
    logic [31:0] m_addr;

    fetch_unit #(.RESET_PC(32'h0000_0000), .FQ_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_a(inst_a), .inst_b(inst_b), .pc_a(pc_a), .pc_b(pc_b),
        .valid_a(valid_a), .valid_b(valid_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: the word at byte address a holds a>>2.
    function automatic logic [63:0] mem_pair(input logic [31:0] a);
        logic [31:0] w;
        w = {2'b00, a[31:2]};
        return {w + 32'd1, w};
    endfunction

    // Instruction memory with configurable response latency (cycles after acceptance).
    always @(posedge clk) begin
        if (reset) begin
            m_cnt       <= 0;
            imem_rvalid <= 1'b0;
        end else begin
            imem_rvalid <= 1'b0;
            if (m_cnt == 1) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= mem_pair(m_addr);
                m_cnt       <= 0;
            end else if (m_cnt > 1) begin
                m_cnt <= m_cnt - 1;
            end
            if (imem_req && imem_ready) begin
                if (lat == 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= mem_pair(imem_addr);
                end else begin
                    m_addr <= imem_addr;
                    m_cnt  <= lat - 1;
                end
            end
        end
    end

    typedef struct {
        logic        st;
        logic        fl;
        logic [31:0] tg;
        logic        va;
        logic [31:0] pa;
        logic [31:0] ia;
        logic        vb;
        logic [31:0] pb;
        logic [31:0] ib;
        logic        rq;
        logic [31:0] ad;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, input logic fl, input logic [31:0] tg,
                       input logic va, input logic [31:0] pa, input logic [31:0] ia,
                       input logic vb, input logic [31:0] pb, input logic [31:0] ib,
                       input logic rq, input logic [31:0] ad);
        vec_t v;
        v.st = st; v.fl = fl; v.tg = tg;
        v.va = va; v.pa = pa; v.ia = ia;
        v.vb = vb; v.pb = pb; v.ib = ib;
        v.rq = rq; v.ad = ad;
        vecs.push_back(v);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Samples at the falling edge, compares every output, then advances one cycle.
    task automatic check_cycle(input string tag,
                               input logic va, input logic [31:0] pa, input logic [31:0] ia,
                               input logic vb, input logic [31:0] pb, input logic [31:0] ib,
                               input logic rq, input logic [31:0] ad);
        @(negedge clk);
        cmp({tag, ".valid_a"}, {31'd0, valid_a}, {31'd0, va});
        cmp({tag, ".pc_a"}, pc_a, pa);
        cmp({tag, ".inst_a"}, inst_a, ia);
        cmp({tag, ".valid_b"}, {31'd0, valid_b}, {31'd0, vb});
        cmp({tag, ".pc_b"}, pc_b, pb);
        cmp({tag, ".inst_b"}, inst_b, ib);
        cmp({tag, ".imem_req"}, {31'd0, imem_req}, {31'd0, rq});
        cmp({tag, ".imem_addr"}, imem_addr, ad);
        $display("%s: va=%0b pc_a=%h inst_a=%h vb=%0b pc_b=%h inst_b=%h req=%0b addr=%h",
                 tag, valid_a, pc_a, inst_a, valid_b, pc_b, inst_b, imem_req, imem_addr);
        cyc();
    endtask

    task automatic idle(input string tag, input logic rq, input logic [31:0] ad);
        check_cycle(tag, 1'b0, 32'd0, NOP, 1'b0, 32'd0, NOP, rq, ad);
    endtask

    // Two cycles of reset, outputs checked while held; returns at cycle 0.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        cyc();
        idle(tag, 1'b0, 32'h0);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_total = 0;
        n_bad = 0;
        lat = 1;
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        branch_taken = 1'b0;
        branch_target = 32'h0;
        imem_ready = 1'b1;

        // Streaming, stall backpressure and odd-word redirect, one row per cycle.
        //   st    fl    tgt           va    pc_a          inst_a        vb    pc_b          inst_b        req   addr
        add(1'b0, 1'b0, 32'h0,       1'b0, 32'h0,   NOP,          1'b0, 32'h0,   NOP,          1'b1, 32'h000); // c0
        add(1'b0, 1'b0, 32'h0,       1'b0, 32'h0,   NOP,          1'b0, 32'h0,   NOP,          1'b0, 32'h008); // c1
        add(1'b0, 1'b0, 32'h0,       1'b1, 32'h0,   32'h0,        1'b1, 32'h4,   32'h1,        1'b1, 32'h008); // c2
        add(1'b0, 1'b0, 32'h0,       1'b0, 32'h0,   NOP,          1'b0, 32'h0,   NOP,          1'b0, 32'h010); // c3
        add(1'b0, 1'b0, 32'h0,       1'b1, 32'h8,   32'h2,        1'b1, 32'hC,   32'h3,        1'b1, 32'h010); // c4
        add(1'b0, 1'b0, 32'h0,       1'b0, 32'h0,   NOP,          1'b0, 32'h0,   NOP,          1'b0, 32'h018); // c5
        add(1'b0, 1'b0, 32'h0,       1'b1, 32'h10,  32'h4,        1'b1, 32'h14,  32'h5,        1'b1, 32'h018); // c6
        add(1'b1, 1'b0, 32'h0,       1'b0, 32'h0,   NOP,          1'b0, 32'h0,   NOP,          1'b0, 32'h020); // c7
        add(1'b1, 1'b0, 32'h0,       1'b1, 32'h18,  32'h6,        1'b1, 32'h1C,  32'h7,        1'b1, 32'h020); // c8
        add(1'b1, 1'b0, 32'h0,       1'b1, 32'h18,  32'h6,        1'b1, 32'h1C,  32'h7,        1'b0, 32'h028); // c9
        add(1'b1, 1'b0, 32'h0,       1'b1, 32'h18,  32'h6,        1'b1, 32'h1C,  32'h7,        1'b0, 32'h028); // c10
        add(1'b1, 1'b0, 32'h0,       1'b1, 32'h18,  32'h6,        1'b1, 32'h1C,  32'h7,        1'b0, 32'h028); // c11
        add(1'b1, 1'b0, 32'h0,       1'b1, 32'h18,  32'h6,        1'b1, 32'h1C,  32'h7,        1'b0, 32'h028); // c12
        add(1'b0, 1'b0, 32'h0,       1'b1, 32'h18,  32'h6,        1'b1, 32'h1C,  32'h7,        1'b0, 32'h028); // c13
        add(1'b0, 1'b0, 32'h0,       1'b1, 32'h20,  32'h8,        1'b1, 32'h24,  32'h9,        1'b1, 32'h028); // c14
        add(1'b0, 1'b0, 32'h0,       1'b0, 32'h0,   NOP,          1'b0, 32'h0,   NOP,          1'b0, 32'h030); // c15
        add(1'b0, 1'b1, 32'h104,     1'b1, 32'h28,  32'hA,        1'b1, 32'h2C,  32'hB,        1'b0, 32'h030); // c16
        add(1'b0, 1'b0, 32'h0,       1'b0, 32'h0,   NOP,          1'b0, 32'h0,   NOP,          1'b1, 32'h100); // c17
        add(1'b0, 1'b0, 32'h0,       1'b0, 32'h0,   NOP,          1'b0, 32'h0,   NOP,          1'b0, 32'h108); // c18
        add(1'b0, 1'b0, 32'h0,       1'b1, 32'h104, 32'h41,       1'b0, 32'h0,   NOP,          1'b1, 32'h108); // c19
        add(1'b0, 1'b0, 32'h0,       1'b0, 32'h0,   NOP,          1'b0, 32'h0,   NOP,          1'b0, 32'h110); // c20
        add(1'b0, 1'b0, 32'h0,       1'b1, 32'h108, 32'h42,       1'b1, 32'h10C, 32'h43,       1'b1, 32'h110); // c21

        do_reset("reset");
        for (int i = 0; i < vecs.size(); i++) begin
            stall         = vecs[i].st;
            flush         = vecs[i].fl;
            branch_taken  = vecs[i].fl;
            branch_target = vecs[i].tg;
            check_cycle($sformatf("vec%0d", i), vecs[i].va, vecs[i].pa, vecs[i].ia,
                        vecs[i].vb, vecs[i].pb, vecs[i].ib, vecs[i].rq, vecs[i].ad);
        end
        stall = 1'b0;
        flush = 1'b0;
        branch_taken = 1'b0;

        // Flush while a 3-cycle response is in flight: stale data never shows.
        lat = 3;
        do_reset("inflight.rst");
        idle("inflight.k0", 1'b1, 32'h000);
        flush = 1'b1; branch_taken = 1'b1; branch_target = 32'h200;
        idle("inflight.k1", 1'b0, 32'h008);
        flush = 1'b0; branch_taken = 1'b0;
        idle("inflight.k2", 1'b0, 32'h200);
        idle("inflight.k3", 1'b0, 32'h200);
        idle("inflight.k4", 1'b1, 32'h200);
        idle("inflight.k5", 1'b0, 32'h208);
        idle("inflight.k6", 1'b0, 32'h208);
        idle("inflight.k7", 1'b0, 32'h208);
        check_cycle("inflight.k8", 1'b1, 32'h200, 32'h80, 1'b1, 32'h204, 32'h81, 1'b1, 32'h208);

        // Flush coincident with the response, then a redirect that wraps at 2^32.
        lat = 1;
        do_reset("coinc.rst");
        idle("coinc.k0", 1'b1, 32'h000);
        flush = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
        idle("coinc.k1", 1'b0, 32'h008);
        flush = 1'b0; branch_taken = 1'b0;
        idle("coinc.k2", 1'b1, 32'h040);
        idle("coinc.k3", 1'b0, 32'h048);
        flush = 1'b1; branch_taken = 1'b1; branch_target = 32'hFFFF_FFFA;
        check_cycle("coinc.k4", 1'b1, 32'h40, 32'h10, 1'b1, 32'h44, 32'h11, 1'b0, 32'h048);
        flush = 1'b0; branch_taken = 1'b0;
        idle("wrap.k5", 1'b1, 32'hFFFF_FFF8);
        idle("wrap.k6", 1'b0, 32'h0000_0000);
        check_cycle("wrap.k7", 1'b1, 32'hFFFF_FFF8, 32'h3FFF_FFFE,
                    1'b1, 32'hFFFF_FFFC, 32'h3FFF_FFFF, 1'b1, 32'h0000_0000);

        // Reset asserted while a request is outstanding.
        lat = 3;
        do_reset("midrst.rst");
        idle("midrst.k0", 1'b1, 32'h000);
        reset = 1'b1;
        idle("midrst.k1", 1'b0, 32'h000);
        lat = 1;
        idle("midrst.k2", 1'b0, 32'h000);
        reset = 1'b0;
        idle("midrst.k3", 1'b1, 32'h000);
        idle("midrst.k4", 1'b0, 32'h008);
        check_cycle("midrst.k5", 1'b1, 32'h0, 32'h0, 1'b1, 32'h4, 32'h1, 1'b1, 32'h008);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
